// File: rtl/chnevt_gen.sv
// rtl/chnevt_gen.sv - per-channel DMA event trigger generator toward the ETB
// Optional feature: define CHNEVT_ACK_EN to hold each trigger until etb_dmacchn_ack.
// Without it the trigger is a fixed one-cycle pulse and the ack input is unused.
module chnevt_gen #(
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             hclk,
  input  logic             hrst_n,
  input  logic             chnc_gbc_chnen,
  input  logic [1:0]       chnc_gbc_evtsel,
  input  logic             chnc_gbc_evtclr,
  input  logic             chnctrl_blk_done,
  input  logic             chnctrl_trans_done,
  input  logic             etb_dmacchn_ack,
  output logic             dmacchn_etb_trg,
  output logic [CNT_W-1:0] chnevt_pend_cnt,
  output logic             chnevt_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      GAP_M1  = (GAP > 0) ? GAP - 1 : 0;
  localparam state_t           ST_POST = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   pend_cnt;
  logic               ovf;
  logic [3:0]         gap_cnt;
  logic [1:0]         inc;
  logic               issue_start;
  logic               issue_done;
  logic [CNT_W+1:0]   cnt_sum;

  // A clear in the same cycle discards pending events, so it also blocks a new issue.
  assign issue_start = (state == ST_IDLE) && (pend_cnt != '0) && !chnc_gbc_evtclr;

`ifdef CHNEVT_ACK_EN
  assign issue_done = etb_dmacchn_ack;
`else
  logic ack_unused;
  assign ack_unused = etb_dmacchn_ack;
  assign issue_done = 1'b1;
`endif

  assign inc = {1'b0, chnctrl_blk_done & chnc_gbc_evtsel[0]}
             + {1'b0, chnctrl_trans_done & chnc_gbc_evtsel[1]};

  // Two guard bits so the net inc/dec result can be compared against the ceiling.
  assign cnt_sum = {2'b00, pend_cnt}
                 + {{CNT_W{1'b0}}, inc}
                 - {{(CNT_W+1){1'b0}}, issue_start};

  // State register; channel disable forces the FSM back to idle.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n)
      state <= ST_IDLE;
    else if (!chnc_gbc_chnen)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode for idle / issue / gap spacing.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue_start)     state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue_done)      state_nxt = ST_POST;
      ST_GAP:   if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Trigger is a pure decode of the state register.
  always_comb begin
    dmacchn_etb_trg = (state == ST_ISSUE);
  end

  // Gap down-counter, loaded as the issue phase ends.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n)
      gap_cnt <= 4'd0;
    else if (!chnc_gbc_chnen)
      gap_cnt <= 4'd0;
    else if ((state == ST_ISSUE) && (state_nxt == ST_GAP))
      gap_cnt <= 4'(GAP_M1);
    else if ((state == ST_GAP) && (gap_cnt != 4'd0))
      gap_cnt <= gap_cnt - 4'd1;
  end

  // Saturating pending counter with sticky overflow; disable beats clear beats inc/dec.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else if (!chnc_gbc_chnen || chnc_gbc_evtclr) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else if (cnt_sum > {2'b00, CNT_MAX}) begin
      pend_cnt <= CNT_MAX;
      ovf      <= 1'b1;
    end else begin
      pend_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  assign chnevt_pend_cnt = pend_cnt;
  assign chnevt_ovf      = ovf;

endmodule

// File: tb/tb_chnevt_gen.sv
// tb/tb_chnevt_gen.sv - randomized and directed bench for chnevt_gen
module tb_chnevt_gen;

  localparam int CNT_W = 4;
  localparam int GAP   = 2;
  localparam int MAXC  = 15;
`ifdef CHNEVT_ACK_EN
  localparam bit ACK_MODE = 1'b1;
`else
  localparam bit ACK_MODE = 1'b0;
`endif

  logic             hclk = 1'b0;
  logic             hrst_n = 1'b0;
  logic             chnen = 1'b0;
  logic [1:0]       evtsel = 2'b00;
  logic             evtclr = 1'b0;
  logic             blk = 1'b0;
  logic             trans = 1'b0;
  logic             ack = 1'b0;
  logic             trg;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: pending events, sticky loss flag, cycles since current trigger began (-1 = free)
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  int m_since = -1;

  chnevt_gen #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .hclk               (hclk),
    .hrst_n             (hrst_n),
    .chnc_gbc_chnen     (chnen),
    .chnc_gbc_evtsel    (evtsel),
    .chnc_gbc_evtclr    (evtclr),
    .chnctrl_blk_done   (blk),
    .chnctrl_trans_done (trans),
    .etb_dmacchn_ack    (ack),
    .dmacchn_etb_trg    (trg),
    .chnevt_pend_cnt    (cnt),
    .chnevt_ovf         (ovf)
  );

  always #5 hclk = ~hclk;

  function automatic bit m_trg();
    return (m_since == 0);
  endfunction

  function automatic bit m_busy();
    return (m_cnt > 0) || (m_since >= 0);
  endfunction

  // Drive one cycle of inputs from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic step(input bit en, input logic [1:0] sel, input bit clr,
                      input bit b, input bit t, input bit a);
    int inc;
    int dec;
    int sum;
    chnen = en; evtsel = sel; evtclr = clr; blk = b; trans = t; ack = a;
    @(posedge hclk);
    if (!en) begin
      m_cnt = 0; m_ovf = 1'b0; m_since = -1;
    end else begin
      inc = int'(b && sel[0]) + int'(t && sel[1]);
      dec = 0;
      if (m_since < 0) begin
        if (m_cnt > 0 && !clr) begin
          m_since = 0;
          dec = 1;
        end
      end else if (m_since > 0 || !ACK_MODE || a) begin
        m_since++;
        if (m_since > GAP) m_since = -1;
      end
      sum = m_cnt + inc - dec;
      if (clr) begin
        m_cnt = 0; m_ovf = 1'b0;
      end else if (sum > MAXC) begin
        m_cnt = MAXC; m_ovf = 1'b1;
      end else begin
        m_cnt = sum;
      end
    end
    @(negedge hclk);
  endtask

  task automatic drain();
    int guard = 0;
    while (m_busy() && guard < 100) begin
      step(1, 2'b00, 0, 0, 0, 1);
      guard++;
    end
    n_total++;
    if (m_busy() || cnt !== 4'd0 || trg !== 1'b0)
      $display("FAIL drain: cnt=%0d trg=%b did not settle within 100 cycles", cnt, trg);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    hrst_n = 1'b0;
    #12;
    n_total++;
    if ({trg, cnt, ovf} !== 6'b0)
      $display("FAIL reset: trg/cnt/ovf=%b/%0d/%b required 0/0/0", trg, cnt, ovf);
    else
      n_pass++;
    @(negedge hclk);
    hrst_n = 1'b1;
    m_cnt = 0; m_ovf = 1'b0; m_since = -1;
    step(1, 2'b00, 0, 0, 0, 0);
    n_total++;
    if ({trg, cnt, ovf} !== 6'b0)
      $display("FAIL reset_release: trg/cnt/ovf=%b/%0d/%b required 0/0/0", trg, cnt, ovf);
    else
      n_pass++;
  endtask

  task automatic test_single_event();
    drain();
    step(1, 2'b01, 0, 1, 0, 1);
    n_total++;
    if (cnt !== 4'd1 || trg !== 1'b0)
      $display("FAIL single_e0: cnt=%0d trg=%b required 1/0", cnt, trg);
    else
      n_pass++;
    step(1, 2'b01, 0, 0, 0, 1);
    n_total++;
    if (cnt !== 4'd0 || trg !== 1'b1)
      $display("FAIL single_e1: cnt=%0d trg=%b required 0/1", cnt, trg);
    else
      n_pass++;
    step(1, 2'b01, 0, 0, 0, 1);
    n_total++;
    if (trg !== 1'b0)
      $display("FAIL single_e2: trg=%b required 0", trg);
    else
      n_pass++;
  endtask

  task automatic test_both_sources();
    int rises[$];
    drain();
    step(1, 2'b11, 0, 1, 1, 1);
    n_total++;
    if (cnt !== 4'd2)
      $display("FAIL both_cnt: cnt=%0d required 2", cnt);
    else
      n_pass++;
    for (int i = 0; i < 12; i++) begin
      step(1, 2'b11, 0, 0, 0, 1);
      if (trg === 1'b1) rises.push_back(i);
      n_total++;
      if ({trg, cnt, ovf} !== {m_trg(), 4'(m_cnt), m_ovf})
        $display("FAIL both_cyc%0d: trg/cnt/ovf=%b/%0d/%b required %b/%0d/%b",
                 i, trg, cnt, ovf, m_trg(), m_cnt, m_ovf);
      else
        n_pass++;
    end
    n_total++;
    if (rises.size() != 2 || rises[1] - rises[0] != GAP + 2)
      $display("FAIL both_spacing: %0d triggers, spacing %0d required 2 triggers spacing %0d",
               rises.size(), (rises.size() == 2) ? rises[1] - rises[0] : -1, GAP + 2);
    else
      n_pass++;
  endtask

  task automatic test_saturation();
    int seen = 0;
    drain();
    for (int i = 0; i < 17; i++) step(1, 2'b11, 0, 1, 1, 1);
    n_total++;
    if (cnt !== 4'(MAXC) || ovf !== 1'b1)
      $display("FAIL sat_hold: cnt=%0d ovf=%b required %0d/1", cnt, ovf, MAXC);
    else
      n_pass++;
    step(1, 2'b11, 1, 1, 1, 1);
    n_total++;
    if (cnt !== 4'd0 || ovf !== 1'b0)
      $display("FAIL sat_clear: cnt=%0d ovf=%b required 0/0", cnt, ovf);
    else
      n_pass++;
    for (int i = 0; i < 20; i++) begin
      step(1, 2'b11, 0, 0, 0, 1);
      if (trg === 1'b1) seen++;
    end
    n_total++;
    if (seen != 0 || cnt !== 4'd0)
      $display("FAIL sat_after_clear: %0d triggers cnt=%0d required 0/0", seen, cnt);
    else
      n_pass++;
  endtask

  task automatic test_channel_disable();
    drain();
    step(1, 2'b11, 0, 1, 1, 0);
    step(1, 2'b11, 0, 1, 1, 0);
    n_total++;
    if (cnt !== 4'd3 || trg !== 1'b1)
      $display("FAIL dis_setup: cnt=%0d trg=%b required 3/1", cnt, trg);
    else
      n_pass++;
    step(0, 2'b11, 0, 1, 1, 0);
    n_total++;
    if ({trg, cnt, ovf} !== 6'b0)
      $display("FAIL dis_drop: trg/cnt/ovf=%b/%0d/%b required 0/0/0", trg, cnt, ovf);
    else
      n_pass++;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b11, 0, 1, 1, 1);
      n_total++;
      if ({trg, cnt} !== 5'b0)
        $display("FAIL dis_events%0d: trg/cnt=%b/%0d required 0/0", i, trg, cnt);
      else
        n_pass++;
    end
    step(1, 2'b00, 0, 0, 0, 1);
    n_total++;
    if ({trg, cnt} !== 5'b0)
      $display("FAIL dis_reenable: trg/cnt=%b/%0d required 0/0 (late ack must be ignored)", trg, cnt);
    else
      n_pass++;
  endtask

  task automatic test_filtering();
    drain();
    for (int i = 0; i < 6; i++) begin
      step(1, 2'b10, 0, 1, 0, 1);
      n_total++;
      if ({trg, cnt} !== 5'b0)
        $display("FAIL filter%0d: trg/cnt=%b/%0d required 0/0", i, trg, cnt);
      else
        n_pass++;
    end
  endtask

`ifdef CHNEVT_ACK_EN
  task automatic test_ack_hold();
    int high = 0;
    drain();
    step(1, 2'b01, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'b01, 0, 0, 0, 0);
      if (trg === 1'b1) high++;
    end
    n_total++;
    if (high != 5)
      $display("FAIL ack_hold: trigger high %0d cycles required 5", high);
    else
      n_pass++;
    step(1, 2'b01, 0, 0, 0, 1);
    n_total++;
    if (trg !== 1'b0)
      $display("FAIL ack_fall: trg=%b required 0", trg);
    else
      n_pass++;
  endtask
`endif

  task automatic test_async_reset();
    drain();
    step(1, 2'b01, 0, 1, 0, 1);
    step(1, 2'b01, 0, 0, 0, 0);
    n_total++;
    if (trg !== 1'b1)
      $display("FAIL arst_setup: trg=%b required 1", trg);
    else
      n_pass++;
    hrst_n = 1'b0;
    #1;
    n_total++;
    if ({trg, cnt, ovf} !== 6'b0)
      $display("FAIL arst_now: trg/cnt/ovf=%b/%0d/%b required 0/0/0", trg, cnt, ovf);
    else
      n_pass++;
    m_cnt = 0; m_ovf = 1'b0; m_since = -1;
    @(negedge hclk);
    hrst_n = 1'b1;
  endtask

  task automatic test_random();
    int bad = 0;
    bit en, clr, b, t, a;
    logic [1:0] sel;
    drain();
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 99) >= 3);
      clr = ($urandom_range(0, 99) < 3);
      sel = 2'($urandom_range(0, 3));
      b   = ($urandom_range(0, 99) < 45);
      t   = ($urandom_range(0, 99) < 45);
      a   = ($urandom_range(0, 99) < 40);
      step(en, sel, clr, b, t, a);
      n_total++;
      if ({trg, cnt, ovf} !== {m_trg(), 4'(m_cnt), m_ovf}) begin
        if (bad < 10)
          $display("FAIL rand_cyc%0d: trg/cnt/ovf=%b/%0d/%b required %b/%0d/%b",
                   i, trg, cnt, ovf, m_trg(), m_cnt, m_ovf);
        bad++;
      end else begin
        n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_both_sources();
    test_saturation();
    test_channel_disable();
    test_filtering();
`ifdef CHNEVT_ACK_EN
    test_ack_hold();
`endif
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chnevt_gen.md
# chnevt_gen

Per-channel DMA event transmitter that drives the channel's outgoing trigger toward the event trigger block (ETB), the counterpart to the channel's inbound trigger latching. It collects block-done and transfer-done completions from the channel controller, queues them in a saturating pending counter, and issues them as spaced trigger pulses on `dmacchn_etb_trg`. One instance sits in each DMA channel, beside the channel control registers.

## Interface
Parameters:
- `CNT_W`, default 4: pending-event counter width; max pending = 2^CNT_W-1.
- `GAP`, default 2: minimum idle cycles after each issued trigger, 0..15.

Ports:
- `hclk` in 1: clock.
- `hrst_n` in 1: reset, asynchronous, active-low.
- `chnc_gbc_chnen` in 1: channel enable; low = synchronous clear of the whole block.
- `chnc_gbc_evtsel` in 2: source select. 00 none, 01 block done, 10 transfer done, 11 both.
- `chnc_gbc_evtclr` in 1: one-cycle pulse; clears pending count and overflow flag.
- `chnctrl_blk_done` in 1: one-cycle block-complete pulse.
- `chnctrl_trans_done` in 1: one-cycle transfer-complete pulse.
- `etb_dmacchn_ack` in 1: ETB acknowledge. Used only when `CHNEVT_ACK_EN` is defined; ignored otherwise.
- `dmacchn_etb_trg` out 1: trigger to ETB.
- `chnevt_pend_cnt` out CNT_W: current pending count.
- `chnevt_ovf` out 1: sticky flag; an event was lost to saturation.

## Operation
- Increment per cycle: `inc` = (`blk_done` & `evtsel[0]`) + (`trans_done` & `evtsel[1]`), range 0..2.
- Decrement: `dec` = 1 on the IDLE->ISSUE transition.
- Next count = min(cnt + inc - dec, max). If cnt + inc - dec > max, set `chnevt_ovf`.
- `chnc_gbc_evtclr` has priority over inc/dec and clears both count and overflow. Events arriving in the same cycle are dropped.
- `chnc_gbc_chnen` low has highest priority: count = 0, ovf = 0, state = IDLE, and the gap counter is cleared. While it is low, all event inputs are ignored.
- FSM states:
  - IDLE: if cnt > 0, go to ISSUE and decrement.
  - ISSUE: `dmacchn_etb_trg` = 1. Without ACK mode, stay one cycle, then go to GAP (or IDLE if GAP = 0). With ACK mode, stay until `etb_dmacchn_ack` is sampled high, then go to GAP (or IDLE).
  - GAP: a down-counter loaded with GAP-1. Return to IDLE when it reaches 0.
- `dmacchn_etb_trg` is decoded only from the state register. There is no combinational path from any input.
- Reset values: `dmacchn_etb_trg` = 0, `chnevt_pend_cnt` = 0, `chnevt_ovf` = 0, state = IDLE.

## Timing
- Event pulse sampled at edge E gives cnt = 1 after E. The next edge enters ISSUE (cnt back to 0). The trigger is high in the cycle after E+1, so latency is 2 cycles from the sampled pulse to the trigger.
- Non-ACK throughput: one trigger per GAP+2 cycles. With GAP = 0, this is one trigger every 2 cycles.
- Simultaneous inc and dec in the same cycle are both applied, and net arithmetic decides saturation. For example, cnt = 15, inc = 1, dec = 1 gives 15 with no overflow.
- `chnen` dropping while in ISSUE forces the trigger low from the next cycle. A pending ack is abandoned, and a later ack in IDLE is ignored.
- An async reset mid-ISSUE forces the trigger low immediately.

## Configuration
- `CHNEVT_ACK_EN` defined: ISSUE holds the trigger high until `etb_dmacchn_ack` = 1, so each event is handshaken. An ack sampled in the same edge as ISSUE entry does not count; the ack must be sampled while in ISSUE.
- `CHNEVT_ACK_EN` undefined: the trigger is a fixed one-cycle pulse, the ack input is unused, and no ack-wait logic is built.

## Test plan
- Single event: `evtsel` = 01, one `blk_done` pulse -> trigger high for exactly 1 cycle, 2 cycles after the pulse; cnt goes 1 then 0.
- Both sources: `evtsel` = 11, `blk_done` and `trans_done` in the same cycle -> cnt = 2; with GAP = 2, two triggers issue 4 cycles apart.
- Saturation: CNT_W = 4, 17 back-to-back `blk_done` pulses with the trigger path busy -> cnt holds 15 and `chnevt_ovf` = 1. Then assert `evtclr` -> cnt = 0, ovf = 0, and no further triggers.
- Channel disable: cnt = 3 while in ISSUE, then drop `chnen` -> trigger low the next cycle, cnt = 0; events while disabled leave cnt = 0.
- ACK mode (`CHNEVT_ACK_EN`): ack withheld for 5 cycles -> trigger stays high for 5 cycles, falls the cycle after ack is sampled, then GAP idle cycles follow.
- Filtering: `evtsel` = 10 with `blk_done` pulses only -> no trigger and cnt stays 0.
